// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | id_ex_stage_pkg : bundle widths, bit indices, FSM codes, helpers |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package id_ex_stage_pkg;
  localparam int WB_W  = 2;
  localparam int MEM_W = 3;
  localparam int EX_W  = 4;
  localparam int CNT_W = 16;

  localparam int WB_REGWRITE_BIT  = 1;
  localparam int WB_MEMTOREG_BIT  = 0;
  localparam int MEM_BRANCH_BIT   = 2;
  localparam int MEM_READ_BIT     = 1;
  localparam int MEM_WRITE_BIT    = 0;
  localparam int EX_REGDST_BIT    = 3;
  localparam int EX_ALUOP1_BIT    = 2;
  localparam int EX_ALUOP0_BIT    = 1;
  localparam int EX_ALUSRC_BIT    = 0;

  localparam logic [0:0] ST_BUBBLE = 1'b0;
  localparam logic [0:0] ST_LOADED = 1'b1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction
endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | id_ex_stage_if : ID-side inputs and EX-side outputs of ID/EX reg |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic [id_ex_stage_pkg::WB_W-1:0]  WB_in,  WB_out;
  logic [id_ex_stage_pkg::MEM_W-1:0] MEM_in, MEM_out;
  logic [id_ex_stage_pkg::EX_W-1:0]  EX_in,  EX_out;
  logic [DATA_W-1:0] PCPlus4_in, ReadData1_in, ReadData2_in, SignExt_in;
  logic [DATA_W-1:0] PCPlus4_out, ReadData1_out, ReadData2_out, SignExt_out;
  logic [REG_W-1:0]  Rs_in, Rt_in, Rd_in, Rs_out, Rt_out, Rd_out;
  logic              Flush;
  logic              Valid_out;
  logic              Stall;
  logic [id_ex_stage_pkg::CNT_W-1:0] BubbleCount;

  modport master (
    output WB_in, MEM_in, EX_in, PCPlus4_in, ReadData1_in, ReadData2_in,
           SignExt_in, Rs_in, Rt_in, Rd_in, Flush,
    input  WB_out, MEM_out, EX_out, PCPlus4_out, ReadData1_out, ReadData2_out,
           SignExt_out, Rs_out, Rt_out, Rd_out, Valid_out, Stall, BubbleCount
  );

  modport slave (
    input  WB_in, MEM_in, EX_in, PCPlus4_in, ReadData1_in, ReadData2_in,
           SignExt_in, Rs_in, Rt_in, Rd_in, Flush,
    output WB_out, MEM_out, EX_out, PCPlus4_out, ReadData1_out, ReadData2_out,
           SignExt_out, Rs_out, Rt_out, Rd_out, Valid_out, Stall, BubbleCount
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_detect : load-use comparison between EX load and ID srcs  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             mem_read_ex,
  input  logic [REG_W-1:0] rt_ex,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  output logic             stall
);
  // $0 is hardwired zero, so a load targeting it never creates a dependency
  assign stall = mem_read_ex && (rt_ex != '0) && ((rt_ex == rs_id) || (rt_ex == rt_id));
endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | id_ex_stage : ID/EX pipeline register with bubble insertion.     |
// | Load-use stall detection enabled by macro LOAD_USE_STALL_EN.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);
  logic [WB_W-1:0]   r_wb;
  logic [MEM_W-1:0]  r_mem;
  logic [EX_W-1:0]   r_ex;
  logic [DATA_W-1:0] r_pc, r_rd1, r_rd2, r_se;
  logic [REG_W-1:0]  r_rs, r_rt, r_rd;
  logic [0:0]        r_state;
  logic [0:0]        w_next_state;
  logic              w_valid;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic              w_stall;
  logic              w_bubble;

`ifdef LOAD_USE_STALL_EN
  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .mem_read_ex (r_mem[MEM_READ_BIT]),
    .rt_ex       (r_rt),
    .rs_id       (bus.Rs_in),
    .rt_id       (bus.Rt_in),
    .stall       (w_stall)
  );
`else
  assign w_stall = 1'b0;
`endif

  // Flush and stall together still produce a single bubble
  assign w_bubble = bus.Flush | w_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_BUBBLE;
      r_wb         <= '0;
      r_mem        <= '0;
      r_ex         <= '0;
      r_pc         <= '0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_se         <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_state      <= w_next_state;
      r_wb         <= w_bubble ? '0 : bus.WB_in;
      r_mem        <= w_bubble ? '0 : bus.MEM_in;
      r_ex         <= w_bubble ? '0 : bus.EX_in;
      r_pc         <= bus.PCPlus4_in;
      r_rd1        <= bus.ReadData1_in;
      r_rd2        <= bus.ReadData2_in;
      r_se         <= bus.SignExt_in;
      r_rs         <= bus.Rs_in;
      r_rt         <= bus.Rt_in;
      r_rd         <= bus.Rd_in;
      r_bubble_cnt <= w_bubble ? sat_inc(r_bubble_cnt) : r_bubble_cnt;
    end
  end

  always_comb begin
    w_next_state = ST_LOADED;
    if (w_bubble) w_next_state = ST_BUBBLE;
  end

  always_comb begin
    w_valid = 1'b0;
    if (r_state == ST_LOADED) w_valid = 1'b1;
  end

  assign bus.WB_out        = r_wb;
  assign bus.MEM_out       = r_mem;
  assign bus.EX_out        = r_ex;
  assign bus.PCPlus4_out   = r_pc;
  assign bus.ReadData1_out = r_rd1;
  assign bus.ReadData2_out = r_rd2;
  assign bus.SignExt_out   = r_se;
  assign bus.Rs_out        = r_rs;
  assign bus.Rt_out        = r_rt;
  assign bus.Rd_out        = r_rd;
  assign bus.Valid_out     = w_valid;
  assign bus.Stall         = w_stall;
  assign bus.BubbleCount   = r_bubble_cnt;
endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_id_ex_stage : directed + random checks against a simple model |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_id_ex_stage;
`ifdef LOAD_USE_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  id_ex_stage_if #(.DATA_W(32), .REG_W(5)) bus ();
  id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Expected architectural contents of the EX slot
  logic [1:0]  m_wb;
  logic [2:0]  m_mem;
  logic [3:0]  m_ex;
  logic [31:0] m_pc, m_rd1, m_rd2, m_se;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic        m_valid;
  logic [15:0] m_cnt;
  bit          m_init = 0;
  bit          m_data_known = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] ex,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic flush);
    bus.WB_in = wb; bus.MEM_in = mem; bus.EX_in = ex;
    bus.Rs_in = rs; bus.Rt_in = rt; bus.Rd_in = rd; bus.Flush = flush;
    bus.PCPlus4_in = $urandom; bus.ReadData1_in = $urandom;
    bus.ReadData2_in = $urandom; bus.SignExt_in = $urandom;
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_wb"},    bus.WB_out,      m_wb);
    chk({pfx, "_mem"},   bus.MEM_out,     m_mem);
    chk({pfx, "_ex"},    bus.EX_out,      m_ex);
    chk({pfx, "_valid"}, bus.Valid_out,   m_valid);
    chk({pfx, "_cnt"},   bus.BubbleCount, m_cnt);
    if (m_data_known) begin
      chk({pfx, "_pc"},  bus.PCPlus4_out,   m_pc);
      chk({pfx, "_rd1"}, bus.ReadData1_out, m_rd1);
      chk({pfx, "_rd2"}, bus.ReadData2_out, m_rd2);
      chk({pfx, "_se"},  bus.SignExt_out,   m_se);
      chk({pfx, "_rs"},  bus.Rs_out,        m_rs);
      chk({pfx, "_rt"},  bus.Rt_out,        m_rt);
      chk({pfx, "_rd"},  bus.Rd_out,        m_rd);
    end
  endtask

  // One clock: check Stall for the current inputs, advance the model, check outputs
  task automatic step(input string pfx, input bit chk_en);
    logic exp_stall;
    bit   bubble;
    #1;
    exp_stall = STALL_EN && m_mem[1] && (m_rt != 5'd0) &&
                ((m_rt == bus.Rs_in) || (m_rt == bus.Rt_in));
    if (chk_en && m_init) chk({pfx, "_stall"}, bus.Stall, exp_stall);
    @(posedge clk);
    if (rst) begin
      m_wb = 0; m_mem = 0; m_ex = 0; m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_se = 0;
      m_rs = 0; m_rt = 0; m_rd = 0; m_valid = 0; m_cnt = 0;
      m_init = 1; m_data_known = 1;
    end else begin
      bubble = bus.Flush || exp_stall;
      m_wb  = bubble ? 2'b0 : bus.WB_in;
      m_mem = bubble ? 3'b0 : bus.MEM_in;
      m_ex  = bubble ? 4'b0 : bus.EX_in;
      m_pc = bus.PCPlus4_in; m_rd1 = bus.ReadData1_in;
      m_rd2 = bus.ReadData2_in; m_se = bus.SignExt_in;
      m_rs = bus.Rs_in; m_rt = bus.Rt_in; m_rd = bus.Rd_in;
      m_valid = !bubble;
      m_data_known = !bubble;
      if (bubble && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    #1;
    if (chk_en) check_outputs(pfx);
  endtask

  initial begin
    logic [15:0] cnt_before;

    // Reset held two cycles with busy inputs
    drive(2'b11, 3'b010, 4'hF, 5'd5, 5'd5, 5'd7, 1'b1);
    rst = 1'b1;
    step("rst0", 1);
    step("rst1", 1);
    chk("rst_stall", bus.Stall, 1'b0);
    rst = 1'b0;

    // Pass-through
    drive(2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 5'd3, 1'b0);
    bus.ReadData1_in = 32'h1234;
    step("pt", 1);
    chk("pt_wb_const",  bus.WB_out, 2'b10);
    chk("pt_ex_const",  bus.EX_out, 4'b1100);
    chk("pt_rd1_const", bus.ReadData1_out, 32'h1234);
    chk("pt_valid_const", bus.Valid_out, 1'b1);

    // Load-use on Rs
    drive(2'b11, 3'b010, 4'b0001, 5'd1, 5'd5, 5'd0, 1'b0);
    step("lw", 1);
    cnt_before = bus.BubbleCount;
    drive(2'b10, 3'b000, 4'b1000, 5'd5, 5'd2, 5'd4, 1'b0);
    #1 chk("lu_stall_const", bus.Stall, STALL_EN);
    step("lu", 1);
    chk("lu_valid_const", bus.Valid_out, !STALL_EN);
    chk("lu_cnt_const", bus.BubbleCount, cnt_before + 16'(STALL_EN));
    chk("lu_stall_clear", bus.Stall, 1'b0);
    step("lu_retry", 1);

    // Load into $0 never stalls
    drive(2'b11, 3'b010, 4'b0001, 5'd1, 5'd0, 5'd0, 1'b0);
    step("lw0", 1);
    cnt_before = bus.BubbleCount;
    drive(2'b10, 3'b000, 4'b1000, 5'd0, 5'd0, 5'd4, 1'b0);
    step("z0", 1);
    chk("z0_valid_const", bus.Valid_out, 1'b1);
    chk("z0_cnt_const", bus.BubbleCount, cnt_before);

    // Flush together with a load-use hazard gives one bubble
    drive(2'b11, 3'b010, 4'b0001, 5'd1, 5'd6, 5'd0, 1'b0);
    step("lw6", 1);
    cnt_before = bus.BubbleCount;
    drive(2'b10, 3'b000, 4'b1000, 5'd6, 5'd2, 5'd4, 1'b1);
    step("fs", 1);
    chk("fs_cnt_const", bus.BubbleCount, cnt_before + 16'd1);
    drive(2'b11, 3'b100, 4'b1111, 5'd1, 5'd2, 5'd3, 1'b1);
    step("fl", 1);
    chk("fl_mem_const", bus.MEM_out, 3'b000);

    // Reset during a pending hazard
    drive(2'b11, 3'b010, 4'b0001, 5'd1, 5'd9, 5'd0, 1'b0);
    step("lw9", 1);
    drive(2'b10, 3'b000, 4'b1000, 5'd9, 5'd2, 5'd4, 1'b0);
    rst = 1'b1;
    step("mrst", 1);
    rst = 1'b0;
    step("mrst_load", 1);
    chk("mrst_valid_const", bus.Valid_out, 1'b1);

    // Randomized traffic with a small register space to provoke hazards
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom), 3'($urandom), 4'($urandom), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom), ($urandom_range(0, 7) == 0));
      rst = ($urandom_range(0, 49) == 0);
      step("rnd", 1);
    end
    rst = 1'b0;

    // Saturation of the bubble counter
    rst = 1'b1;
    step("srst", 1);
    rst = 1'b0;
    drive(2'b11, 3'b000, 4'b0000, 5'd1, 5'd2, 5'd3, 1'b1);
    for (int i = 0; i < 65534; i++) step("pre", 0);
    chk("sat_pre_const", bus.BubbleCount, 16'd65534);
    for (int i = 0; i < 3; i++) step("sat", 1);
    chk("sat_const", bus.BubbleCount, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
